// File: rtl/ibuf_sync_filter.sv
// ---------------------------------------------------------------------------
// ibuf_sync_filter
//
// Receive-side companion to the tri-state output pad buffers. An asynchronous
// pad input is brought into the C domain through a two-flop synchronizer.
// A persistence counter then filters it, so the output O changes only after
// the synchronized level has differed from O for FILTER_LEN consecutive
// edges. Shorter excursions are rejected and counted in GLITCH_CNT, which
// saturates at 255. While the local output driver is on (T = 0), the filter
// is blanked so that the block does not react to its own echo.
//
// Parameters
//   FILTER_LEN : consecutive differing samples required to move O (1..16)
//   INIT       : reset value of the synchronizer flops and of O
//
// Ports
//   C          : clock, rising edge
//   CLR        : asynchronous active-high reset
//   I          : pad input, asynchronous to C
//   T          : 1 = driver off / receive enabled, 0 = driver on / blanked
//   CLR_CNT    : synchronous clear of GLITCH_CNT (wins over an increment)
//   O          : filtered, synchronized level
//   RISE       : one-cycle strobe in the cycle O goes 0->1
//   FALL       : one-cycle strobe in the cycle O goes 1->0
//   GLITCH_CNT : saturating count of rejected glitches
//
// All outputs come straight from flops. No input reaches an output
// combinationally.
// ---------------------------------------------------------------------------
module ibuf_sync_filter #(
  parameter int unsigned FILTER_LEN = 4,
  parameter logic        INIT       = 1'b0
) (
  input  logic       C,
  input  logic       CLR,
  input  logic       I,
  input  logic       T,
  input  logic       CLR_CNT,
  output logic       O,
  output logic       RISE,
  output logic       FALL,
  output logic [7:0] GLITCH_CNT
);

  // The counter only ever needs to reach FILTER_LEN-1. It keeps one bit
  // even for FILTER_LEN = 1, where it simply stays at zero.
  localparam int unsigned   CW       = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);
  localparam logic [7:0]    GCNT_MAX = 8'hFF;

  // Synchronizer stages. s1_q may go metastable; only s2_q is consumed.
  logic s1_q;
  logic s2_q;

  // Filter state and registered outputs.
  logic          o_q,    o_d;
  logic [CW-1:0] cnt_q,  cnt_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;
  logic [7:0]    gcnt_q, gcnt_d;

  // Set when a partial run ends because s2 fell back to O.
  logic          glitch_hit;

  // -------------------------------------------------------------------------
  // Synchronizer: free-running, independent of T, so that s2 already holds
  // the current pad level when blanking ends.
  // -------------------------------------------------------------------------
  always_ff @(posedge C or posedge CLR) begin
    if (CLR) begin
      s1_q <= INIT;
      s2_q <= INIT;
    end else begin
      s1_q <= I;
      s2_q <= s1_q;
    end
  end

  // -------------------------------------------------------------------------
  // Persistence filter, next state.
  // -------------------------------------------------------------------------
  always_comb begin
    o_d        = o_q;
    cnt_d      = cnt_q;
    rise_d     = 1'b0;
    fall_d     = 1'b0;
    glitch_hit = 1'b0;

    if (T) begin
      if (s2_q == o_q) begin
        // A run that ended early is a glitch. A zero count means that no
        // run was in progress.
        cnt_d      = '0;
        glitch_hit = (cnt_q != '0);
      end else if (cnt_q == CNT_LAST) begin
        // This is the FILTER_LEN-th consecutive differing sample, so the
        // new level is accepted.
        o_d    = s2_q;
        cnt_d  = '0;
        rise_d = s2_q;
        fall_d = ~s2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      // Blanked: any partial run is dropped without being counted as a
      // glitch, and O holds its value.
      cnt_d = '0;
    end
  end

  // -------------------------------------------------------------------------
  // Glitch counter, next state. A clear wins over a simultaneous increment.
  // At the maximum the counter holds and never wraps.
  // -------------------------------------------------------------------------
  always_comb begin
    gcnt_d = gcnt_q;
    if (CLR_CNT) begin
      gcnt_d = '0;
    end else if (glitch_hit && (gcnt_q != GCNT_MAX)) begin
      gcnt_d = gcnt_q + 8'd1;
    end
  end

  // -------------------------------------------------------------------------
  // State registers.
  // -------------------------------------------------------------------------
  always_ff @(posedge C or posedge CLR) begin
    if (CLR) begin
      o_q    <= INIT;
      cnt_q  <= '0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      gcnt_q <= '0;
    end else begin
      o_q    <= o_d;
      cnt_q  <= cnt_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      gcnt_q <= gcnt_d;
    end
  end

  assign O          = o_q;
  assign RISE       = rise_q;
  assign FALL       = fall_q;
  assign GLITCH_CNT = gcnt_q;

endmodule

// File: tb/tb_ibuf_sync_filter.sv
// ---------------------------------------------------------------------------
// Bench for ibuf_sync_filter. It uses three instances:
//   dut4 : FILTER_LEN = 4, INIT = 0  (main function, glitches, blanking,
//          saturation, reset mid-filter)
//   dut1 : FILTER_LEN = 1, INIT = 0  (no persistence)
//   duth : FILTER_LEN = 2, INIT = 1  (reset value and latency with INIT high)
// Expected output tuples {O, RISE, FALL, GLITCH_CNT} are queued with the
// edge number at which they must hold. Each negedge pops and compares the
// entries that are due.
// ---------------------------------------------------------------------------
module tb_ibuf_sync_filter;

  localparam int         EW = 29;  // {sel[1:0], edge[15:0], o, rise, fall, gcnt[7:0]}
  localparam logic [1:0] D4 = 2'd0;
  localparam logic [1:0] D1 = 2'd1;
  localparam logic [1:0] DH = 2'd2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic clr;
  int   edge_n = 0;

  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;

  // ---------------- DUT signals ----------------
  logic       i4, t4, cc4, o4, r4, f4;
  logic [7:0] g4;
  logic       i1, t1, cc1, o1, r1, f1;
  logic [7:0] g1;
  logic       ih, th, cch, oh, rh, fh;
  logic [7:0] gh;

  ibuf_sync_filter #(.FILTER_LEN(4), .INIT(1'b0)) dut4 (
    .C(clk), .CLR(clr), .I(i4), .T(t4), .CLR_CNT(cc4),
    .O(o4), .RISE(r4), .FALL(f4), .GLITCH_CNT(g4)
  );

  ibuf_sync_filter #(.FILTER_LEN(1), .INIT(1'b0)) dut1 (
    .C(clk), .CLR(clr), .I(i1), .T(t1), .CLR_CNT(cc1),
    .O(o1), .RISE(r1), .FALL(f1), .GLITCH_CNT(g1)
  );

  ibuf_sync_filter #(.FILTER_LEN(2), .INIT(1'b1)) duth (
    .C(clk), .CLR(clr), .I(ih), .T(th), .CLR_CNT(cch),
    .O(oh), .RISE(rh), .FALL(fh), .GLITCH_CNT(gh)
  );

  // ---------------- scoreboard ----------------
  int             n_vec = 0;
  int             n_err = 0;
  logic [EW-1:0]  exp_q[$];
  string          tag_q[$];

  function automatic logic [10:0] obs(input logic [1:0] sel);
    case (sel)
      D4:      obs = {o4, r4, f4, g4};
      D1:      obs = {o1, r1, f1, g1};
      default: obs = {oh, rh, fh, gh};
    endcase
  endfunction

  task automatic check(input string tag, input logic [10:0] got, input logic [10:0] want);
    n_vec++;
    assert (got === want) else begin
      n_err++;
      $error("FAIL %s: observed {O,R,F,G}=%b_%b_%b_%0d required %b_%b_%b_%0d", tag,
             got[10], got[9], got[8], got[7:0], want[10], want[9], want[8], want[7:0]);
    end
  endtask

  task automatic expect_at(input logic [1:0] sel, input int cyc, input logic [2:0] orf,
                           input logic [7:0] g, input string tag);
    exp_q.push_back({sel, 16'(cyc), orf, g});
    tag_q.push_back(tag);
  endtask

  task automatic check_due();
    logic [EW-1:0] e;
    int            due;
    for (int x = exp_q.size() - 1; x >= 0; x--) begin
      e   = exp_q[x];
      due = int'(e[26:11]);
      if (due == edge_n) begin
        check(tag_q[x], obs(e[28:27]), e[10:0]);
        exp_q.delete(x);
        tag_q.delete(x);
      end else if (due < edge_n) begin
        n_err++;
        $error("FAIL %s: expectation for edge %0d not checked (now edge %0d)", tag_q[x], due, edge_n);
        exp_q.delete(x);
        tag_q.delete(x);
      end
    end
  endtask

  // ---------------- driver ----------------
  // Inputs change just after a negedge. Outputs are sampled at the negedge.
  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      check_due();
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int k, m, r, gv;

    clr = 1'b1;
    i4 = 1'b0; t4 = 1'b1; cc4 = 1'b0;
    i1 = 1'b0; t1 = 1'b1; cc1 = 1'b0;
    ih = 1'b1; th = 1'b1; cch = 1'b0;
    tick(2);

    // Reset values while CLR is held.
    check("rst_dut4", {o4, r4, f4, g4}, 11'h000);
    check("rst_dut1", {o1, r1, f1, g1}, 11'h000);
    check("rst_init1", {oh, rh, fh, gh}, {3'b100, 8'd0});
    clr = 1'b0;

    // INIT=1 instance: quiet with I high, then a fall after FILTER_LEN+1.
    k = edge_n;
    for (int j = 1; j <= 4; j++) expect_at(DH, k + j, 3'b100, 8'd0, "init1_hold");
    tick(4);
    k = edge_n;
    ih = 1'b0;
    expect_at(DH, k + 3, 3'b100, 8'd0, "init1_pre");
    expect_at(DH, k + 4, 3'b001, 8'd0, "init1_fall");
    expect_at(DH, k + 5, 3'b000, 8'd0, "init1_after");
    tick(6);

    // Clean rise and fall with FILTER_LEN=4: latency 5 edges.
    k = edge_n;
    i4 = 1'b1;
    expect_at(D4, k + 5, 3'b000, 8'd0, "rise_pre");
    expect_at(D4, k + 6, 3'b110, 8'd0, "rise_edge");
    expect_at(D4, k + 7, 3'b100, 8'd0, "rise_clear");
    tick(10);
    k = edge_n;
    i4 = 1'b0;
    expect_at(D4, k + 5, 3'b100, 8'd0, "fall_pre");
    expect_at(D4, k + 6, 3'b001, 8'd0, "fall_edge");
    expect_at(D4, k + 7, 3'b000, 8'd0, "fall_clear");
    tick(10);

    // A 3-cycle pulse is rejected and counted once.
    k = edge_n;
    i4 = 1'b1;
    for (int j = 1; j <= 8; j++)
      expect_at(D4, k + j, 3'b000, (j >= 6) ? 8'd1 : 8'd0, "glitch3");
    tick(3);
    i4 = 1'b0;
    tick(7);

    // A 4-cycle pulse is accepted, and the glitch count is unchanged.
    k = edge_n;
    i4 = 1'b1;
    expect_at(D4, k + 5, 3'b000, 8'd1, "pulse4_pre");
    expect_at(D4, k + 6, 3'b110, 8'd1, "pulse4_rise");
    expect_at(D4, k + 7, 3'b100, 8'd1, "pulse4_hold");
    tick(4);
    i4 = 1'b0;
    tick(3);

    // Asynchronous reset mid-cycle while O=1 and GLITCH_CNT=1.
    #2 clr = 1'b1;
    #1 check("async_rst", {o4, r4, f4, g4}, 11'h000);
    tick(2);
    clr = 1'b0;
    tick(2);

    // Seed GLITCH_CNT=1 before blanking.
    k = edge_n;
    i4 = 1'b1;
    expect_at(D4, k + 5, 3'b000, 8'd0, "blank_seed_pre");
    expect_at(D4, k + 6, 3'b000, 8'd1, "blank_seed");
    expect_at(D4, k + 7, 3'b000, 8'd1, "blank_seed_hold");
    tick(3);
    i4 = 1'b0;
    tick(8);

    // Build a partial count of 2, then blank while I toggles every 2 cycles.
    k = edge_n;
    i4 = 1'b1;
    tick(4);
    t4 = 1'b0;
    for (int j = 1; j <= 46; j++) expect_at(D4, edge_n + j, 3'b000, 8'd1, "blank");
    for (int j = 0; j < 20; j++) begin
      i4 = ~i4;
      tick(2);
    end
    tick(3);
    // I has been high long enough for s2 to settle. Receiving resumes now.
    m = edge_n;
    t4 = 1'b1;
    expect_at(D4, m + 4, 3'b110, 8'd1, "unblank_rise");
    expect_at(D4, m + 5, 3'b100, 8'd1, "unblank_hold");
    tick(5);

    // Saturation: 260 three-cycle low glitches against O=1.
    for (int j = 0; j < 260; j++) begin
      k = edge_n;
      i4 = 1'b0;
      gv = (j + 2 > 255) ? 255 : j + 2;
      expect_at(D4, k + 6, 3'b100, 8'(gv), "sat");
      tick(3);
      i4 = 1'b1;
      tick(2);
    end

    // CLR_CNT coinciding with a glitch completion at 255.
    k = edge_n;
    i4 = 1'b0;
    expect_at(D4, k + 6, 3'b100, 8'd0, "clrcnt_sat");
    expect_at(D4, k + 7, 3'b100, 8'd0, "clrcnt_hold");
    tick(3);
    i4 = 1'b1;
    tick(2);
    cc4 = 1'b1;
    tick(1);
    cc4 = 1'b0;

    // Refill to 1, then clear against a live increment (1 -> 0, not 2).
    k = edge_n;
    i4 = 1'b0;
    expect_at(D4, k + 6, 3'b100, 8'd1, "clrcnt_refill");
    tick(3);
    i4 = 1'b1;
    tick(2);
    k = edge_n;
    i4 = 1'b0;
    expect_at(D4, k + 6, 3'b100, 8'd0, "clrcnt_priority");
    tick(3);
    i4 = 1'b1;
    tick(2);
    cc4 = 1'b1;
    tick(1);
    cc4 = 1'b0;
    tick(3);

    // FILTER_LEN=1: a 1-cycle pulse passes through 2 edges later.
    k = edge_n;
    i1 = 1'b1;
    expect_at(D1, k + 2, 3'b000, 8'd0, "fl1_pre");
    expect_at(D1, k + 3, 3'b110, 8'd0, "fl1_rise");
    expect_at(D1, k + 4, 3'b001, 8'd0, "fl1_fall");
    expect_at(D1, k + 5, 3'b000, 8'd0, "fl1_idle");
    tick(1);
    i1 = 1'b0;
    tick(6);

    // Reset while cnt=2, then require the full 5-edge latency again.
    clr = 1'b1;
    tick(2);
    clr = 1'b0;
    k = edge_n;
    expect_at(D4, k + 4, 3'b000, 8'd0, "pre_clr");
    tick(4);
    #2 clr = 1'b1;
    #1 check("midfilt_rst", {o4, r4, f4, g4}, 11'h000);
    tick(2);
    clr = 1'b0;
    r = edge_n;
    expect_at(D4, r + 5, 3'b000, 8'd0, "relatch_pre");
    expect_at(D4, r + 6, 3'b110, 8'd0, "relatch_rise");
    expect_at(D4, r + 7, 3'b100, 8'd0, "relatch_hold");
    tick(8);

    // Drain any outstanding expectations within a bounded window.
    for (int w = 0; w < 50 && exp_q.size() > 0; w++) tick(1);
    while (exp_q.size() > 0) begin
      n_err++;
      $error("FAIL %s: expectation left unchecked at end of run", tag_q[0]);
      void'(exp_q.pop_front());
      void'(tag_q.pop_front());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ibuf_sync_filter.md
# ibuf_sync_filter

Receive-side companion to the tri-state output pad buffers. It samples an asynchronous pad input into the `C` domain through a two-flop synchronizer and rejects glitches with a persistence counter. It then presents a clean level plus single-cycle rise and fall strobes, and counts rejected glitches. It sits between the input or bidirectional pad and core logic. While the local output driver is enabled, the block blanks its own echo.

## Interface

Parameters:
- `FILTER_LEN`, default 4: number of consecutive cycles the synchronized input must differ from `O` before `O` changes. Legal range is 1..16.
- `INIT`, default 1'b0: reset value of the synchronizer flops and of `O`.

Ports:
- `C`, input, 1: clock. All state is rising-edge triggered.
- `CLR`, input, 1: reset. Asynchronous and active-high.
- `I`, input, 1: pad input. Asynchronous to `C`.
- `T`, input, 1: tri-state control of the companion output buffer. 1 = driver off, receive enabled. 0 = local driver on, filter blanked.
- `CLR_CNT`, input, 1: synchronous clear of `GLITCH_CNT`.
- `O`, output, 1: filtered, synchronized level.
- `RISE`, output, 1: one-cycle strobe. High in the cycle `O` goes 0→1.
- `FALL`, output, 1: one-cycle strobe. High in the cycle `O` goes 1→0.
- `GLITCH_CNT`, output, 8: count of rejected glitches. Saturates at 255.

## Operation

Reset (`CLR`=1, asynchronous) sets:
- `s1`, `s2`, `O` to `INIT`
- `cnt`, `RISE`, `FALL`, `GLITCH_CNT` to 0

Synchronizer:
- `s1 <= I`, `s2 <= s1` on every edge, regardless of `T`.
- Only `s2` feeds the filter.

Filter, evaluated on every edge when `T`=1. The state is `O` plus `cnt`, where `cnt` is wide enough to hold `FILTER_LEN-1`.
- `s2 == O`:
  - `cnt <= 0`.
  - If `cnt != 0`, this is a rejected glitch: `GLITCH_CNT` increments, saturating at 255.
- `s2 != O` and `cnt == FILTER_LEN-1`:
  - `O <= s2`, `cnt <= 0`.
  - `RISE <= s2`, `FALL <= ~s2` for that one cycle.
- `s2 != O` and `cnt < FILTER_LEN-1`:
  - `cnt <= cnt+1`.
- `RISE` and `FALL` are 0 on every edge not covered by the update case. They are never high together.

Blanking (`T`=0):
- `cnt <= 0`. `O` holds its value. `RISE` and `FALL` are 0.
- `GLITCH_CNT` does not increment, and a partial count is discarded silently.
- When `T` returns to 1, filtering restarts from `cnt`=0 using the current `s2`.

Glitch counter:
- `CLR_CNT`=1 sets `GLITCH_CNT <= 0`. This takes priority over a simultaneous increment.
- At 255 the counter holds. It never wraps.

`FILTER_LEN`=1: no persistence. `O` follows `s2` one edge later, and `GLITCH_CNT` never increments.

## Timing

- `I` is changed and held stable before rising edge n, with `T`=1 throughout:
  - `s1` updates at edge n.
  - `s2` updates at edge n+1.
  - `O`, `RISE`/`FALL` update at edge n+1+`FILTER_LEN`.
  - Total latency is `FILTER_LEN`+1 cycles.
- A pulse on `s2` lasting fewer than `FILTER_LEN` cycles never reaches `O`. It adds exactly 1 to `GLITCH_CNT` on the edge where `s2` is first seen equal to `O` again.
- A pulse lasting exactly `FILTER_LEN` cycles is accepted.
- Reset mid-filter: everything returns to reset values immediately and asynchronously. After `CLR` deasserts, the full latency applies again.
- Release of `CLR` is synchronous to `C` in the system. The block adds no reset synchronizer.
- Outputs are registered. There is no combinational path from any input to any output.

## Test plan

1. Reset values: assert `CLR` asynchronously, mid-cycle, with `INIT`=0 → `O`=0, `RISE`=`FALL`=0, `GLITCH_CNT`=0 immediately, before the next `C` edge.
2. Clean rise, `FILTER_LEN`=4, `T`=1: `I` 0→1 before edge 10 → `O`=1 and `RISE`=1 at edge 15 only; `RISE`=0 at edge 16. Then `I` 1→0 before edge 30 → `FALL`=1 at edge 35.
3. Glitch rejection, `FILTER_LEN`=4: `I` high for 3 cycles, then low → `O` stays 0, `RISE` is never asserted, `GLITCH_CNT`=1. Repeat with 4 cycles high → `O` goes to 1 and `GLITCH_CNT` stays 1.
4. Blanking: `T`=0 while `I` toggles every 2 cycles for 40 cycles → `O`, `RISE`, `FALL` and `GLITCH_CNT` are unchanged. Then set `T`=1 with `I` held at 1 → `O`=1 `FILTER_LEN` edges after `T` rises.
5. Saturation and clear: inject 260 three-cycle glitches → `GLITCH_CNT`=255. Assert `CLR_CNT` in the same cycle as a glitch completion → `GLITCH_CNT`=0.
6. `FILTER_LEN`=1 with a 1-cycle pulse on `I` → `O` pulses for 1 cycle, 2 edges later, with matching `RISE` and `FALL` strobes. Then assert `CLR` while `cnt`=2 under `FILTER_LEN`=4 → after release, the full 5-cycle latency is required.
